seq_multiplier_4b: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/adder_4b.sv | 21 ++
 rtl/seq_multiplier_4b.sv | 118 +++++++++++
 tb/tb_seq_multiplier_4b.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: multiplier widths, iteration count and FSM state encoding.
// The op decoder reuses the ST_* values, so keep them stable.
package alu_pkg;

    localparam int MUL_W  = 4;
    localparam int PROD_W = 8;

    localparam logic [2:0] MUL_ITERS = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } mul_state_e;

endpackage

// File: rtl/adder_4b.sv
// 4-bit ripple-carry adder; the multiplier's only arithmetic resource.
module adder_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[4];

endmodule

// File: rtl/seq_multiplier_4b.sv
// Unsigned shift-and-add multiplier, one adder_4b iteration per RUN cycle.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module seq_multiplier_4b
    import alu_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int ZERO_BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    if (WIDTH != MUL_W) begin : g_width_check
        $error("seq_multiplier_4b: WIDTH must be %0d", MUL_W);
    end

    mul_state_e         state_q, state_d;
    logic [MUL_W-1:0]   mcand_q, mcand_d;
    logic [MUL_W-1:0]   acc_q, acc_d;
    logic [MUL_W-1:0]   q_q, q_d;
    logic [2:0]         count_q, count_d;
    logic [PROD_W-1:0]  product_q, product_d;

    logic [MUL_W-1:0]   addend;
    logic [MUL_W-1:0]   add_sum;
    logic               add_cout;
    logic [MUL_W-1:0]   acc_shift;
    logic [MUL_W-1:0]   q_shift;
    logic               zero_operand;

    assign addend = q_q[0] ? mcand_q : '0;

    adder_4b u_adder (
        .a    (acc_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // {carry, acc, q} shifted right by one: the carry lands in acc[3].
    assign acc_shift    = {add_cout, add_sum[MUL_W-1:1]};
    assign q_shift      = {add_sum[0], q_q[MUL_W-1:1]};
    assign zero_operand = (a == '0) || (b == '0);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        q_d       = q_q;
        count_d   = count_q;
        product_d = product_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    q_d     = b;
                    acc_d   = '0;
                    count_d = MUL_ITERS;
                    if ((ZERO_BYPASS != 0) && zero_operand) begin
                        product_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d   = acc_shift;
                q_d     = q_shift;
                count_d = count_q - 3'd1;
                if (count_q == 3'd1) begin
                    product_d = {acc_shift, q_shift};
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign out_valid = (state_q == S_DONE);
    assign product   = product_q;

endmodule

// File: tb/tb_seq_multiplier_4b.sv
// Directed bench for seq_multiplier_4b: latency, zero bypass, backpressure, async reset, full a/b sweep.
module tb_seq_multiplier_4b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] product;
    logic       busy;

    int checks = 0;
    int passed = 0;

    localparam int WAIT_LIMIT = 20;

    seq_multiplier_4b #(
        .WIDTH       (4),
        .ZERO_BYPASS (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Driver: present operands for one edge; returns 1 time unit after the accept edge.
    task automatic send(input logic [3:0] av, input logic [3:0] bv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Driver: wait for out_valid, counting edges and busy samples; bounded by WAIT_LIMIT.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (out_valid !== 1'b1 && edges < WAIT_LIMIT) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 4'd0;
        b         = 4'd0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
        checks++; if (product !== 8'd0) $display("FAIL reset_product got=%0d exp=0", product); else passed++;
        #21;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); else passed++;
    endtask

    task automatic test_basic_13x11();
        int edges, bc;
        send(4'd13, 4'd11);
        checks++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_drop got=%b exp=0", in_ready); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL basic_busy_rise got=%b exp=1", busy); else passed++;
        wait_done(edges, bc);
        checks++; if (edges != 4) $display("FAIL basic_latency got=%0d exp=4", edges); else passed++;
        checks++; if (bc != 4) $display("FAIL basic_busy_cycles got=%0d exp=4", bc); else passed++;
        checks++; if (product !== 8'd143) $display("FAIL basic_product got=%0d exp=143", product); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy_in_done got=%b exp=0", busy); else passed++;
        consume();
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_out_valid_clear got=%b exp=0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL basic_back_to_idle got=%b exp=1", in_ready); else passed++;
        checks++; if (product !== 8'd143) $display("FAIL basic_product_retained got=%0d exp=143", product); else passed++;
    endtask

    task automatic test_max_15x15();
        int edges, bc;
        send(4'd15, 4'd15);
        wait_done(edges, bc);
        checks++; if (edges != 4) $display("FAIL max_latency got=%0d exp=4", edges); else passed++;
        checks++; if (product !== 8'hE1) $display("FAIL max_product got=%0d exp=225", product); else passed++;
        consume();
    endtask

    task automatic test_zero_bypass();
        int edges, bc;
        send(4'd0, 4'd9);
        checks++; if (out_valid !== 1'b1) $display("FAIL zero_a_out_valid got=%b exp=1", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL zero_a_busy got=%b exp=0", busy); else passed++;
        checks++; if (product !== 8'd0) $display("FAIL zero_a_product got=%0d exp=0", product); else passed++;
        consume();
        send(4'd7, 4'd0);
        wait_done(edges, bc);
        checks++; if (edges != 0) $display("FAIL zero_b_latency got=%0d exp=0", edges); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL zero_b_busy got=%b exp=0", busy); else passed++;
        checks++; if (product !== 8'd0) $display("FAIL zero_b_product got=%0d exp=0", product); else passed++;
        consume();
    endtask

    task automatic test_backpressure();
        int edges, bc;
        send(4'd6, 4'd5);
        wait_done(edges, bc);
        checks++; if (edges != 4) $display("FAIL bp_latency got=%0d exp=4", edges); else passed++;
        in_valid = 1'b1;
        a        = 4'd3;
        b        = 4'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, out_valid); else passed++;
            checks++; if (product !== 8'd30) $display("FAIL bp_hold_product[%0d] got=%0d exp=30", i, product); else passed++;
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_hold_in_ready[%0d] got=%b exp=0", i, in_ready); else passed++;
        end
        // in_valid stays high across the output handshake: only the output side may complete.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_idle_after_consume got=%b exp=1", in_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL bp_no_accept_in_done got=%b exp=0", busy); else passed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL bp_next_accept got=%b exp=1", busy); else passed++;
        wait_done(edges, bc);
        checks++; if (product !== 8'd9) $display("FAIL bp_next_product got=%0d exp=9", product); else passed++;
        consume();
    endtask

    task automatic test_reset_mid_run();
        int edges, bc;
        send(4'd9, 4'd9);
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) $display("FAIL abort_in_run got=%b exp=1", busy); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid got=%b exp=0", out_valid); else passed++;
        checks++; if (product !== 8'd0) $display("FAIL abort_product got=%0d exp=0", product); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready got=%b exp=1", in_ready); else passed++;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(4'd2, 4'd3);
        wait_done(edges, bc);
        checks++; if (edges != 4) $display("FAIL abort_after_latency got=%0d exp=4", edges); else passed++;
        checks++; if (product !== 8'd6) $display("FAIL abort_after_product got=%0d exp=6", product); else passed++;
        consume();
    endtask

    task automatic test_exhaustive();
        logic [7:0] exp_p;
        int handshakes, cycles;
        logic seen;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                exp_p = 8'(ia * ib);
                send(4'(ia), 4'(ib));
                handshakes = 0;
                cycles     = 0;
                seen       = 1'b0;
                while (handshakes == 0 && cycles < WAIT_LIMIT) begin
                    if (out_valid === 1'b1 && !seen) begin
                        seen = 1'b1;
                        checks++; if (product !== exp_p) $display("FAIL sweep_product a=%0d b=%0d got=%0d exp=%0d", ia, ib, product, exp_p); else passed++;
                    end
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid === 1'b1 && out_ready === 1'b1) handshakes++;
                    @(posedge clk);
                    #1;
                    cycles++;
                end
                out_ready = 1'b0;
                checks++; if (handshakes != 1) $display("FAIL sweep_handshake a=%0d b=%0d got=%0d exp=1", ia, ib, handshakes); else passed++;
                checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL sweep_idle a=%0d b=%0d got=%b%b exp=01", ia, ib, out_valid, in_ready); else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_13x11();
        test_max_15x15();
        test_zero_bypass();
        test_backpressure();
        test_reset_mid_run();
        test_exhaustive();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
